vproc_mem_target: RTL and testbench

VPROC_MEM_TARGET -- requirements
Module: vproc_mem_target

---
 rtl/vproc_mem_target.sv | 238 +++++++++++++++++++++++
 tb/tb_vproc_mem_target.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vproc_mem_target.sv
// vproc_mem_target: single-port word memory slave with wait states, byte enables,
// burst-beat tracking and a sticky protocol error counter.
//
// Parameters: ARCH_WIDTH (32|64), MEM_ADDR_WIDTH (log2 words), WAIT_STATES (0..15),
//             NODE (instance label used in elaboration messages).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr, be, wr, rd, wdata  request: byte address, byte enables, write/read, write data
//   rdata, wrack, rdack      response: read data (held between read acks), one-cycle acks
//   burst, burst_first/last  burst beat count and beat markers
//   err, err_count           sticky error flag, saturating error counter
// Optional feature: define VPROC_TGT_RANGE_CHECK_EN to flag addresses beyond the memory
// (write dropped, read returns all-ones). Undefined: upper address bits are ignored.
module vproc_mem_target #(
    parameter int ARCH_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_STATES    = 0,
    parameter int NODE           = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARCH_WIDTH-1:0]   addr,
    input  logic [ARCH_WIDTH/8-1:0] be,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ARCH_WIDTH-1:0]   wdata,
    output logic [ARCH_WIDTH-1:0]   rdata,
    output logic                    wrack,
    output logic                    rdack,
    input  logic [11:0]             burst,
    input  logic                    burst_first,
    input  logic                    burst_last,
    output logic                    err,
    output logic [7:0]              err_count
);

    localparam int unsigned BE_W   = ARCH_WIDTH / 8;
    localparam int unsigned LSB_W  = (ARCH_WIDTH == 64) ? 3 : 2;
    localparam int unsigned IDX_HI = MEM_ADDR_WIDTH + LSB_W;
    localparam int unsigned DEPTH  = 1 << MEM_ADDR_WIDTH;
    localparam int unsigned WS_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Elaboration-time parameter legality checks
    if (!(ARCH_WIDTH == 32 || ARCH_WIDTH == 64)) begin : g_bad_arch
        $fatal(1, "vproc_mem_target node %0d: illegal ARCH_WIDTH %0d", NODE, ARCH_WIDTH);
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $fatal(1, "vproc_mem_target node %0d: illegal WAIT_STATES %0d", NODE, WAIT_STATES);
    end

    logic [ARCH_WIDTH-1:0]     mem [DEPTH];

    logic [1:0]                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [BE_W-1:0]           be_q, be_d;
    logic [ARCH_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      is_wr_q, is_wr_d;
    logic                      rng_q, rng_d;
    logic [WS_W-1:0]           cnt_q, cnt_d;
    logic [11:0]               beat_q, beat_d;
    logic [ARCH_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      wrack_q, wrack_d;
    logic                      rdack_q, rdack_d;
    logic                      err_q, err_d;
    logic [7:0]                err_cnt_q, err_cnt_d;

    logic                      req_c;
    logic [MEM_ADDR_WIDTH-1:0] idx_c;
    logic                      rng_err_c;
    logic [11:0]               cur_beat_c;
    logic                      burst_err_c;
    logic                      go_ack_c;
    logic                      err_evt_c;
    logic                      mem_we_c;
    logic [MEM_ADDR_WIDTH-1:0] acc_idx_c;
    logic [BE_W-1:0]           acc_be_c;
    logic [ARCH_WIDTH-1:0]     acc_wdata_c;
    logic                      acc_wr_c;
    logic                      acc_rng_c;
    logic                      unused_ok;

    assign req_c = rd | wr;
    assign idx_c = addr[IDX_HI-1:LSB_W];

`ifdef VPROC_TGT_RANGE_CHECK_EN
    assign rng_err_c = |addr[ARCH_WIDTH-1:IDX_HI];
`else
    assign rng_err_c = 1'b0;
`endif

    // Byte-offset bits never select data; NODE only labels messages
    assign unused_ok = ^{addr[LSB_W-1:0], addr[ARCH_WIDTH-1:IDX_HI], (NODE != 0)};

    // burst_first restarts beat numbering on the beat that carries it
    assign cur_beat_c  = burst_first ? 12'd0 : beat_q;
    assign burst_err_c = burst_last && (burst != 12'd0) && ((cur_beat_c + 12'd1) != burst);

    // Next-state, response and error bookkeeping
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rng_d       = rng_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        rdata_d     = rdata_q;
        wrack_d     = 1'b0;
        rdack_d     = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        go_ack_c    = 1'b0;
        err_evt_c   = 1'b0;
        mem_we_c    = 1'b0;
        acc_idx_c   = idx_q;
        acc_be_c    = be_q;
        acc_wdata_c = wdata_q;
        acc_wr_c    = is_wr_q;
        acc_rng_c   = rng_q;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    idx_d       = idx_c;
                    be_d        = be;
                    wdata_d     = wdata;
                    is_wr_d     = wr;
                    rng_d       = rng_err_c;
                    beat_d      = cur_beat_c;
                    err_evt_c   = (rd & wr) | burst_err_c | rng_err_c;
                    // Zero-wait accesses complete on this edge, so use the live request
                    acc_idx_c   = idx_c;
                    acc_be_c    = be;
                    acc_wdata_c = wdata;
                    acc_wr_c    = wr;
                    acc_rng_c   = rng_err_c;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_W'(WAIT_STATES - 1);
                    end else begin
                        go_ack_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_c) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    go_ack_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Edge entering ACK: commit write or capture read data
        if (go_ack_c) begin
            state_d = ST_ACK;
            beat_d  = beat_d + 12'd1;
            if (acc_wr_c) begin
                wrack_d  = 1'b1;
                mem_we_c = !acc_rng_c && !rst;
            end else begin
                rdack_d = 1'b1;
                rdata_d = acc_rng_c ? {ARCH_WIDTH{1'b1}} : mem[acc_idx_c];
            end
        end

        if (err_evt_c) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            rng_q     <= 1'b0;
            cnt_q     <= '0;
            beat_q    <= '0;
            rdata_q   <= '0;
            wrack_q   <= 1'b0;
            rdack_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            rng_q     <= rng_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
            wrack_q   <= wrack_d;
            rdack_q   <= rdack_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Memory array is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (acc_be_c[b]) begin
                    mem[acc_idx_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign wrack     = wrack_q;
    assign rdack     = rdack_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_vproc_mem_target.sv
// Directed bench for vproc_mem_target: a zero-wait instance (u_dut0) carries the
// table-driven vectors, bursts, error and saturation cases; a three-wait instance
// (u_dut1) covers latency, abandoned access and reset-in-WAIT.
module tb_vproc_mem_target;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr0, rd0, wr1, rd1;
    logic [31:0] rdata0, rdata1;
    logic        wrack0, rdack0, wrack1, rdack1;
    logic [11:0] burst;
    logic        burst_first, burst_last;
    logic        err0, err1;
    logic [7:0]  err_count0, err_count1;

    int passed = 0;
    int total  = 0;

    vproc_mem_target #(.ARCH_WIDTH(32), .MEM_ADDR_WIDTH(10), .WAIT_STATES(0), .NODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr), .be(be), .wr(wr0), .rd(rd0), .wdata(wdata),
        .rdata(rdata0), .wrack(wrack0), .rdack(rdack0), .burst(burst),
        .burst_first(burst_first), .burst_last(burst_last), .err(err0), .err_count(err_count0)
    );

    vproc_mem_target #(.ARCH_WIDTH(32), .MEM_ADDR_WIDTH(10), .WAIT_STATES(3), .NODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .be(be), .wr(wr1), .rd(rd1), .wdata(wdata),
        .rdata(rdata1), .wrack(wrack1), .rdack(rdack1), .burst(burst),
        .burst_first(burst_first), .burst_last(burst_last), .err(err1), .err_count(err_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One request held until acked (or 40-cycle budget); lat = cycles to ack, -1 on timeout
    task automatic access(input int sel, input logic w, input logic r, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output int lat, output logic saw_wr, output logic saw_rd);
        @(negedge clk);
        addr = a; be = b; wdata = d;
        if (sel == 0) begin wr0 = w; rd0 = r; end
        else begin wr1 = w; rd1 = r; end
        lat = 0; saw_wr = 1'b0; saw_rd = 1'b0;
        while (lat < 40 && !saw_wr && !saw_rd) begin
            @(negedge clk);
            lat++;
            saw_wr = (sel == 0) ? wrack0 : wrack1;
            saw_rd = (sel == 0) ? rdack0 : rdack1;
        end
        wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        if (!(saw_wr || saw_rd)) lat = -1;
    endtask

    // Acks must be gone on the following cycle
    task automatic check_pulse(input string name, input int sel);
        @(negedge clk);
        check(name, 64'((sel == 0) ? (wrack0 | rdack0) : (wrack1 | rdack1)), 64'd0);
    endtask

    initial begin
        vec_t vecs[12];
        int   lat;
        logic sw, sr, seen;

        vecs[0]  = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h12345678, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h10, 4'hF, 32'h0,        32'h12345678};
        vecs[2]  = '{1'b1, 1'b0, 32'h20, 4'hF, 32'hAABBCCDD, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h20, 4'h5, 32'h11223344, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h0,        32'hAA22CC44};
        vecs[5]  = '{1'b1, 1'b0, 32'h24, 4'hF, 32'h00000000, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h24, 4'hA, 32'hCAFEBABE, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h24, 4'hF, 32'h0,        32'hCA00BA00};
        vecs[8]  = '{1'b0, 1'b1, 32'h11, 4'hF, 32'h0,        32'h12345678};
        vecs[9]  = '{1'b1, 1'b0, 32'h13, 4'h2, 32'h0000EE00, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h10, 4'hF, 32'h0,        32'h1234EE78};
        vecs[11] = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h0,        32'hAA22CC44};

        rst = 1'b1; addr = '0; be = '0; wdata = '0;
        wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        burst = '0; burst_first = 1'b0; burst_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata0", 64'(rdata0), 64'd0);
        check("rst_acks0", 64'({wrack0, rdack0}), 64'd0);
        check("rst_err0", 64'({err0, err_count0}), 64'd0);
        check("rst_rdata1", 64'(rdata1), 64'd0);
        check("rst_acks1", 64'({wrack1, rdack1}), 64'd0);
        rst = 1'b0;

        // Table-driven accesses on the zero-wait instance
        for (int i = 0; i < 12; i++) begin
            access(0, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].d, lat, sw, sr);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            check($sformatf("vec%0d_ack_kind", i), 64'({sw, sr}), 64'({vecs[i].w, vecs[i].r}));
            if (vecs[i].r) check($sformatf("vec%0d_rdata", i), 64'(rdata0), 64'(vecs[i].exp));
            check_pulse($sformatf("vec%0d_pulse", i), 0);
        end
        check("table_err", 64'({err0, err_count0}), 64'd0);

        // wr and rd together: write only, protocol error, rdata keeps last read
        access(0, 1'b1, 1'b1, 32'h50, 4'hF, 32'h5555AAAA, lat, sw, sr);
        check("both_ack_kind", 64'({sw, sr}), 64'b10);
        check("both_rdata_held", 64'(rdata0), 64'hAA22CC44);
        check("both_err", 64'({err0, err_count0}), 64'h101);
        access(0, 1'b0, 1'b1, 32'h50, 4'hF, 32'h0, lat, sw, sr);
        check("both_readback", 64'(rdata0), 64'h5555AAAA);

        // Three wait states: ack four cycles after the request is sampled
        access(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0BADF00D, lat, sw, sr);
        check("ws3_wr_latency", 64'(lat), 64'd4);
        access(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0, lat, sw, sr);
        check("ws3_rd_latency", 64'(lat), 64'd4);
        check("ws3_rdata", 64'(rdata1), 64'h0BADF00D);
        check_pulse("ws3_pulse", 1);

        // Request dropped during WAIT: abandoned, nothing written
        @(negedge clk);
        addr = 32'h40; be = 4'hF; wdata = 32'h11111111; wr1 = 1'b1;
        @(negedge clk);
        wr1 = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (wrack1) seen = 1'b1; end
        check("abandon_no_wrack", 64'(seen), 64'd0);
        access(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0, lat, sw, sr);
        check("abandon_readback", 64'(rdata1), 64'h0BADF00D);

        // Reset while a write sits in WAIT
        @(negedge clk);
        addr = 32'h40; be = 4'hF; wdata = 32'hDEADBEEF; wr1 = 1'b1;
        seen = 1'b0;
        @(negedge clk); if (wrack1) seen = 1'b1;
        @(negedge clk); if (wrack1) seen = 1'b1;
        rst = 1'b1;
        @(negedge clk); if (wrack1) seen = 1'b1;
        rst = 1'b0; wr1 = 1'b0;
        repeat (5) begin @(negedge clk); if (wrack1) seen = 1'b1; end
        check("rstwait_no_wrack", 64'(seen), 64'd0);
        check("rstwait_err_cleared", 64'({err0, err_count0}), 64'd0);
        check("rstwait_rdata_cleared", 64'(rdata0), 64'd0);
        access(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0, lat, sw, sr);
        check("rstwait_readback", 64'(rdata1), 64'h0BADF00D);

        // Well-formed 4-beat burst
        burst = 12'd4;
        for (int i = 0; i < 4; i++) begin
            burst_first = (i == 0);
            burst_last  = (i == 3);
            access(0, 1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h10000000 + 32'(i), lat, sw, sr);
            check($sformatf("burst_ok_beat%0d", i), 64'({sw, lat == 1}), 64'b11);
        end
        check("burst_ok_err", 64'({err0, err_count0}), 64'd0);

        // burst_last on the third beat of a 4-beat burst
        for (int i = 0; i < 3; i++) begin
            burst_first = (i == 0);
            burst_last  = (i == 2);
            access(0, 1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h20000000 + 32'(i), lat, sw, sr);
        end
        burst = '0; burst_first = 1'b0; burst_last = 1'b0;
        check("burst_short_err", 64'({err0, err_count0}), 64'h101);

        // Address above the memory range
        access(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0, lat, sw, sr);
        check("range_ack", 64'(sr), 64'd1);
`ifdef VPROC_TGT_RANGE_CHECK_EN
        check("range_rdata", 64'(rdata0), 64'hFFFFFFFF);
        check("range_err_count", 64'(err_count0), 64'd2);
`else
        check("range_rdata", 64'(rdata0), 64'h20000000);
        check("range_err_count", 64'(err_count0), 64'd1);
`endif

        // err_count saturates
        for (int i = 0; i < 300; i++) begin
            access(0, 1'b1, 1'b1, 32'h60, 4'hF, 32'(i), lat, sw, sr);
        end
        check("err_count_saturate", 64'({err0, err_count0}), 64'h1FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
